// File: rtl/full_adder_pkg.sv
// Shared constants and the golden add function for the full_adder family.
package full_adder_pkg;

  localparam int FA_MAX_WIDTH = 64;

  typedef logic [FA_MAX_WIDTH:0] fa_wide_t;

  // Returns {cout, s} packed at bit 'width' and below; upper bits are zero.
  function automatic fa_wide_t fa_ref(input logic [FA_MAX_WIDTH-1:0] a,
                                      input logic [FA_MAX_WIDTH-1:0] b,
                                      input logic                    cin,
                                      input int                      width);
    fa_wide_t keep;
    fa_wide_t opnd;
    fa_wide_t sum;
    keep = (fa_wide_t'(1) << (width + 1)) - fa_wide_t'(1);
    opnd = keep >> 1;
    sum  = ({1'b0, a} & opnd) + ({1'b0, b} & opnd) + fa_wide_t'(cin);
    return sum & keep;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit combinational full-adder cell; the building block of the ripple chain.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with combinational and one-cycle registered results.
// Optional overflow outputs (ovf, ovf_q) are built when FULL_ADDER_OVF_EN is defined.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] s_q,
  output logic             cout_q,
  output logic             valid_q
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             ovf,
  output logic             ovf_q
`endif
);

  if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_bad_width
    $error("full_adder: WIDTH %0d outside 1..%0d", WIDTH, FA_MAX_WIDTH);
  end

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (s[i]),
      .co (carry[i+1])
    );
  end

  assign cout = carry[WIDTH];

  logic [WIDTH-1:0] s_d;
  logic             cout_d;
  logic             valid_d;

  always_comb begin
    s_d     = s_q;
    cout_d  = cout_q;
    valid_d = valid_q;
    if (en) begin
      s_d     = s;
      cout_d  = cout;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q     <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

`ifdef FULL_ADDER_OVF_EN
  logic ovf_d;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign ovf = carry[WIDTH-1] ^ carry[WIDTH];

  always_comb begin
    ovf_d = ovf_q;
    if (en) begin
      ovf_d = ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
`endif

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder at WIDTH 1, 8 and 16 against an arithmetic model.
`timescale 1ns/1ps
module tb_full_adder;
  import full_adder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_1, b_1, cin_1, en_1, rst_n_1;
  logic        s_1, cout_1, s_q_1, cout_q_1, valid_q_1;
  logic [7:0]  a_8, b_8, s_8, s_q_8;
  logic        cin_8, en_8, rst_n_8, cout_8, cout_q_8, valid_q_8;
  logic [15:0] a_16, b_16, s_16, s_q_16;
  logic        cin_16, en_16, rst_n_16, cout_16, cout_q_16, valid_q_16;
`ifdef FULL_ADDER_OVF_EN
  logic ovf_1, ovf_q_1, ovf_8, ovf_q_8, ovf_16, ovf_q_16;
`endif

  full_adder #(.WIDTH(1)) u_w1 (
    .a(a_1), .b(b_1), .cin(cin_1), .s(s_1), .cout(cout_1),
    .clk(clk), .rst_n(rst_n_1), .en(en_1),
    .s_q(s_q_1), .cout_q(cout_q_1), .valid_q(valid_q_1)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(ovf_1), .ovf_q(ovf_q_1)
`endif
  );

  full_adder #(.WIDTH(8)) u_w8 (
    .a(a_8), .b(b_8), .cin(cin_8), .s(s_8), .cout(cout_8),
    .clk(clk), .rst_n(rst_n_8), .en(en_8),
    .s_q(s_q_8), .cout_q(cout_q_8), .valid_q(valid_q_8)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(ovf_8), .ovf_q(ovf_q_8)
`endif
  );

  full_adder #(.WIDTH(16)) u_w16 (
    .a(a_16), .b(b_16), .cin(cin_16), .s(s_16), .cout(cout_16),
    .clk(clk), .rst_n(rst_n_16), .en(en_16),
    .s_q(s_q_16), .cout_q(cout_q_16), .valid_q(valid_q_16)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(ovf_16), .ovf_q(ovf_q_16)
`endif
  );

  typedef struct {
    int          id;
    string       tag;
    logic [63:0] s;
    logic        c;
    logic        ovf;
    logic [63:0] sq;
    logic        cq;
    logic        vq;
    logic        oq;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          widths[3] = '{1, 8, 16};
  logic [63:0] m_sq[3];
  logic        m_cq[3];
  logic        m_vq[3];
  logic        m_oq[3];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Applies one vector to DUT 'id' at the falling edge and queues what the
  // following rising edge must show. Other instances are parked with en=0.
  task automatic drive(input int id, input string tag, input logic [63:0] a,
                       input logic [63:0] b, input logic cin, input logic en,
                       input logic rst_n);
    exp_t        e;
    int          w;
    logic [63:0] mask, am, bm, full;
    longint      lim, sa, sb, ssum;
    @(negedge clk);
    w    = widths[id];
    mask = (64'h1 << w) - 64'h1;
    am   = a & mask;
    bm   = b & mask;
    en_1 = 1'b0; en_8 = 1'b0; en_16 = 1'b0;
    case (id)
      0: begin a_1 = am[0]; b_1 = bm[0]; cin_1 = cin; en_1 = en; rst_n_1 = rst_n; end
      1: begin a_8 = am[7:0]; b_8 = bm[7:0]; cin_8 = cin; en_8 = en; rst_n_8 = rst_n; end
      default: begin a_16 = am[15:0]; b_16 = bm[15:0]; cin_16 = cin; en_16 = en; rst_n_16 = rst_n; end
    endcase
    full = am + bm + 64'(cin);
    lim  = longint'(1) << (w - 1);
    sa   = longint'(am);
    sb   = longint'(bm);
    if (sa >= lim) sa -= 2 * lim;
    if (sb >= lim) sb -= 2 * lim;
    ssum = sa + sb + longint'(cin);
    e.id  = id;
    e.tag = tag;
    e.s   = full & mask;
    e.c   = full[w];
    e.ovf = (ssum >= lim) || (ssum < -lim);
    if (id == 2) chk({tag, " fa_ref"}, 64'(fa_ref(am, bm, cin, w)), full & ((mask << 1) | 64'h1));
    if (!rst_n) begin
      m_sq[id] = '0; m_cq[id] = 1'b0; m_vq[id] = 1'b0; m_oq[id] = 1'b0;
    end else if (en) begin
      m_sq[id] = e.s; m_cq[id] = e.c; m_vq[id] = 1'b1; m_oq[id] = e.ovf;
    end
    e.sq = m_sq[id];
    e.cq = m_cq[id];
    e.vq = m_vq[id];
    e.oq = m_oq[id];
    sb_q.push_back(e);
  endtask

  // Monitor: one scoreboard entry per driven cycle, compared just after the edge.
  initial begin
    exp_t        e;
    logic [63:0] as, asq;
    logic        ac, acq, avq, aov, aoq;
    forever begin
      @(posedge clk);
      #1;
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        aov = 1'b0; aoq = 1'b0;
        case (e.id)
          0: begin as = 64'(s_1); ac = cout_1; asq = 64'(s_q_1); acq = cout_q_1; avq = valid_q_1;
`ifdef FULL_ADDER_OVF_EN
             aov = ovf_1; aoq = ovf_q_1;
`endif
          end
          1: begin as = 64'(s_8); ac = cout_8; asq = 64'(s_q_8); acq = cout_q_8; avq = valid_q_8;
`ifdef FULL_ADDER_OVF_EN
             aov = ovf_8; aoq = ovf_q_8;
`endif
          end
          default: begin as = 64'(s_16); ac = cout_16; asq = 64'(s_q_16); acq = cout_q_16; avq = valid_q_16;
`ifdef FULL_ADDER_OVF_EN
             aov = ovf_16; aoq = ovf_q_16;
`endif
          end
        endcase
        chk({e.tag, " s"},       as,  e.s);
        chk({e.tag, " cout"},    64'(ac),  64'(e.c));
        chk({e.tag, " s_q"},     asq, e.sq);
        chk({e.tag, " cout_q"},  64'(acq), 64'(e.cq));
        chk({e.tag, " valid_q"}, 64'(avq), 64'(e.vq));
`ifdef FULL_ADDER_OVF_EN
        chk({e.tag, " ovf"},     64'(aov), 64'(e.ovf));
        chk({e.tag, " ovf_q"},   64'(aoq), 64'(e.oq));
`else
        if (aov || aoq) n_fail++;
`endif
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    a_1 = 0; b_1 = 0; cin_1 = 0; en_1 = 0; rst_n_1 = 0;
    a_8 = 0; b_8 = 0; cin_8 = 0; en_8 = 0; rst_n_8 = 0;
    a_16 = 0; b_16 = 0; cin_16 = 0; en_16 = 0; rst_n_16 = 0;
    for (int i = 0; i < 3; i++) begin
      m_sq[i] = '0; m_cq[i] = 1'b0; m_vq[i] = 1'b0; m_oq[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n_1 = 1; rst_n_8 = 1; rst_n_16 = 1;

    for (int i = 0; i < 8; i++)
      drive(0, "w1 sweep", 64'((i >> 2) & 1), 64'((i >> 1) & 1), 1'((i) & 1), 1'b1, 1'b1);

    drive(0, "w1 in reset", 64'd1, 64'd1, 1'b1, 1'b1, 1'b0);
    drive(0, "w1 in reset", 64'd1, 64'd1, 1'b1, 1'b1, 1'b0);
    drive(0, "w1 release",  64'd1, 64'd1, 1'b1, 1'b1, 1'b1);

    drive(0, "w1 capture", 64'd1, 64'd0, 1'b0, 1'b1, 1'b1);
    drive(0, "w1 hold",    64'd1, 64'd1, 1'b0, 1'b0, 1'b1);
    drive(0, "w1 hold",    64'd1, 64'd1, 1'b0, 1'b0, 1'b1);

    drive(1, "w8 wrap",    64'hFF, 64'h01, 1'b0, 1'b1, 1'b1);
    drive(1, "w8 ovf",     64'h7F, 64'h00, 1'b1, 1'b1, 1'b1);
    drive(1, "w8 cap2a",   64'h20, 64'h0A, 1'b0, 1'b1, 1'b1);
    drive(1, "w8 midrst",  64'h11, 64'h22, 1'b0, 1'b1, 1'b0);
    drive(1, "w8 after",   64'h80, 64'h80, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 200; i++)
      drive(1, "w8 rand", 64'($urandom), 64'($urandom), 1'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) != 0));

    for (int i = 0; i < 1000; i++)
      drive(2, "w16 rand", 64'($urandom), 64'($urandom), 1'($urandom), 1'b1, 1'b1);
    drive(2, "w16 max", 64'hFFFF, 64'hFFFF, 1'b1, 1'b1, 1'b1);
    drive(2, "w16 hold", 64'h1234, 64'h4321, 1'b0, 1'b0, 1'b1);

    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard drain", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
